// File: rtl/ldst_dmem_ctrl_pkg.sv
// Shared types and helpers for the LDST data-memory responder: lane codes,
// FSM state encoding, latched RMW payload and lane mask/alignment functions.
package dmem_pkg;

    localparam int unsigned DMEM_DW    = 32;
    localparam int unsigned DMEM_LANES = DMEM_DW / 8;

    typedef enum logic [2:0] {
        LN_B0   = 3'd0,
        LN_B1   = 3'd1,
        LN_B2   = 3'd2,
        LN_B3   = 3'd3,
        LN_HLO  = 3'd4,
        LN_HHI  = 3'd5,
        LN_WORD = 3'd6,
        LN_ILL  = 3'd7
    } lane_code_e;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } dmem_state_e;

    // Lanes captured at a sub-word store accept, consumed in the write-back cycle
    typedef struct packed {
        logic [DMEM_LANES-1:0] mask;
        logic [DMEM_DW-1:0]    data;
    } rmw_lanes_t;

    function automatic logic [DMEM_LANES-1:0] lane_mask(lane_code_e code);
        case (code)
            LN_B0:   lane_mask = 4'b0001;
            LN_B1:   lane_mask = 4'b0010;
            LN_B2:   lane_mask = 4'b0100;
            LN_B3:   lane_mask = 4'b1000;
            LN_HLO:  lane_mask = 4'b0011;
            LN_HHI:  lane_mask = 4'b1100;
            LN_WORD: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    // Move right-aligned store data onto the lanes selected by the code
    function automatic logic [DMEM_DW-1:0] lane_align(lane_code_e code, logic [DMEM_DW-1:0] wdata);
        case (code)
            LN_B0:   lane_align = {24'h0, wdata[7:0]};
            LN_B1:   lane_align = {16'h0, wdata[7:0], 8'h0};
            LN_B2:   lane_align = {8'h0, wdata[7:0], 16'h0};
            LN_B3:   lane_align = {wdata[7:0], 24'h0};
            LN_HLO:  lane_align = {16'h0, wdata[15:0]};
            LN_HHI:  lane_align = {wdata[15:0], 16'h0};
            default: lane_align = wdata;
        endcase
    endfunction

    function automatic logic [DMEM_DW-1:0] mask_bits(logic [DMEM_LANES-1:0] m);
        mask_bits = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage

// File: rtl/ldst_dmem_ctrl_if.sv
// Request/response bus between the LDST unit (master) and the data-memory
// responder (slave).
interface ldst_dmem_ctrl_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 15
);
    logic                 req_valid;
    logic                 req_we;
    logic [AddrWidth-1:0] req_addr;
    logic [2:0]           req_byte_en;
    logic [DataWidth-1:0] req_wdata;
    logic                 rsp_valid;
    logic [DataWidth-1:0] rsp_rdata;
    logic                 rsp_err;
    logic                 dmem_busy;

    modport master (
        output req_valid, req_we, req_addr, req_byte_en, req_wdata,
        input  rsp_valid, rsp_rdata, rsp_err, dmem_busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_byte_en, req_wdata,
        output rsp_valid, rsp_rdata, rsp_err, dmem_busy
    );
endinterface

// File: rtl/ldst_dmem_ctrl_ram.sv
// Single-port synchronous RAM: byte write strobes, 1-cycle registered read.
// A read and a write never share an edge; the write takes priority on we.
module dmem_ram #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 15,
    parameter string       InitFile  = ""
) (
    input  logic                   clk,
    input  logic                   i_en,
    input  logic                   i_we,
    input  logic [DataWidth/8-1:0] i_be,
    input  logic [AddrWidth-1:0]   i_addr,
    input  logic [DataWidth-1:0]   i_wdata,
    output logic [DataWidth-1:0]   o_rdata
);
    localparam int unsigned Depth = 32'(1) << AddrWidth;
    localparam int unsigned Lanes = DataWidth / 8;

    logic [DataWidth-1:0] r_mem [Depth];
    logic [DataWidth-1:0] r_rdata;

    // Image named by InitFile is bound to r_mem by the memory flow
    if (InitFile != "") begin : g_image
    end

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < Lanes; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/ldst_dmem_ctrl.sv
// LDST data-memory responder: word loads/stores, sub-word stores via a
// 2-cycle read-modify-write. Optional error flag under `DMEM_ERR_EN.
module ldst_dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 15,
    parameter string       InitFile  = ""
) (
    input  logic brq_clk,
    input  logic brq_rst,
    ldst_dmem_ctrl_if.slave bus
);
    localparam int unsigned Lanes = DataWidth / 8;
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_RMW  = RMW_WR;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    lane_code_e           w_code;
    logic                 w_accept;
    logic                 w_is_sub;
    logic                 w_is_ill;
    logic                 w_ld;
    logic                 w_ld_ok;
    logic                 w_st_word;
    logic                 w_st_sub;
    logic                 w_ram_en;
    logic                 w_ram_we;
    logic [Lanes-1:0]     w_ram_be;
    logic [AddrWidth-1:0] w_ram_addr;
    logic [DataWidth-1:0] w_ram_wdata;
    logic [DataWidth-1:0] w_ram_rdata;
    logic [DataWidth-1:0] w_merged;
    logic [DataWidth-1:0] w_lane_bits;
    logic [AddrWidth-1:0] r_rmw_addr;
    rmw_lanes_t           r_rmw;
    logic                 r_rsp_valid;
    logic                 r_rd_live;

    // Request decode; requests seen while busy are dropped, not queued
    assign w_code    = lane_code_e'(bus.req_byte_en);
    assign w_accept  = bus.req_valid && (r_state == ST_IDLE);
    assign w_is_sub  = !(bus.req_byte_en[2] && bus.req_byte_en[1]);
    assign w_is_ill  = (w_code == LN_ILL);
    assign w_ld      = w_accept && !bus.req_we;
    assign w_ld_ok   = w_ld && !w_is_ill;
    assign w_st_word = w_accept && bus.req_we && (w_code == LN_WORD);
    assign w_st_sub  = w_accept && bus.req_we && w_is_sub;

    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_st_sub) w_state_nxt = ST_RMW;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_lane_bits = mask_bits(r_rmw.mask);
    assign w_merged    = (w_ram_rdata & ~w_lane_bits) | (r_rmw.data & w_lane_bits);

    // RAM port: write-back owns the port in RMW_WR; reset kills any access
    always_comb begin
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_be    = '1;
        w_ram_addr  = bus.req_addr;
        w_ram_wdata = bus.req_wdata;
        if (r_state == ST_RMW) begin
            w_ram_en    = 1'b1;
            w_ram_we    = 1'b1;
            w_ram_be    = r_rmw.mask;
            w_ram_addr  = r_rmw_addr;
            w_ram_wdata = w_merged;
        end else begin
            w_ram_en = w_ld_ok || w_st_sub || w_st_word;
            w_ram_we = w_st_word;
        end
        if (brq_rst) begin
            w_ram_en = 1'b0;
        end
    end

    dmem_ram #(
        .DataWidth (DataWidth),
        .AddrWidth (AddrWidth),
        .InitFile  (InitFile)
    ) u_ram (
        .clk     (brq_clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_be    (w_ram_be),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            r_rsp_valid <= 1'b0;
            r_rd_live   <= 1'b0;
            r_rmw_addr  <= '0;
            r_rmw       <= '0;
        end else begin
            r_rsp_valid <= w_ld;
            r_rd_live   <= w_ld_ok;
            if (w_st_sub) begin
                r_rmw_addr <= bus.req_addr;
                r_rmw.mask <= lane_mask(w_code);
                r_rmw.data <= lane_align(w_code, bus.req_wdata);
            end
        end
    end

    // Illegal loads and the post-RMW read slot both present zero data
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rd_live ? w_ram_rdata : '0;
    assign bus.dmem_busy = (r_state == ST_RMW);

`ifdef DMEM_ERR_EN
    logic r_err;

    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && (w_is_ill ||
                     (bus.req_we && (w_code == LN_HHI) && (&bus.req_addr)));
        end
    end

    assign bus.rsp_err = r_err;
`else
    assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_ldst_dmem_ctrl.sv
// Directed scoreboard bench for ldst_dmem_ctrl; load expectations are queued
// at issue and retired against the response cycle they are due in.
module tb_ldst_dmem_ctrl;
    import dmem_pkg::*;

`ifdef DMEM_ERR_EN
    localparam logic ErrEn = 1'b1;
`else
    localparam logic ErrEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ldst_dmem_ctrl_if #(.DataWidth(32), .AddrWidth(15)) bus_if ();

    ldst_dmem_ctrl #(
        .DataWidth (32),
        .AddrWidth (15),
        .InitFile  ("")
    ) dut (
        .brq_clk (clk),
        .brq_rst (rst),
        .bus     (bus_if)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc   = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [14:0] addr, input logic [2:0] code,
                         input logic [31:0] wdata);
        bus_if.req_valid   = 1'b1;
        bus_if.req_we      = we;
        bus_if.req_addr    = addr;
        bus_if.req_byte_en = code;
        bus_if.req_wdata   = wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus_if.req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [14:0] addr, input logic [2:0] code,
                        input logic [31:0] exp_data, input logic exp_err);
        sb.push_back('{exp_data, exp_err, cyc + 1});
        drive(1'b0, addr, code, 32'h0);
    endtask

    // Retire due responses; any other cycle must show rsp_valid low
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (sb.size() != 0 && sb[0].due == cyc) begin
                    e = sb.pop_front();
                    chk("rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
                    chk("rsp_rdata", bus_if.rsp_rdata, e.data);
                    chk("rsp_err", 32'(bus_if.rsp_err), 32'(e.err));
                end else begin
                    chk("spurious_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1);
    end

    initial begin
        bus_if.req_valid   = 1'b0;
        bus_if.req_we      = 1'b0;
        bus_if.req_addr    = '0;
        bus_if.req_byte_en = 3'd0;
        bus_if.req_wdata   = '0;
        fork
            monitor();
        join_none
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus_if.rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(bus_if.rsp_err), 32'd0);
        chk("rst_busy", 32'(bus_if.dmem_busy), 32'd0);
        rst = 1'b0;
        idle(1);

        // word store then immediate load of the same address
        drive(1'b1, 15'h10, LN_WORD, 32'hDEADBEEF);
        chk("wst_busy", 32'(bus_if.dmem_busy), 32'd0);
        load(15'h10, LN_WORD, 32'hDEADBEEF, 1'b0);
        chk("wld_busy", 32'(bus_if.dmem_busy), 32'd0);
        idle(2);

        // byte RMW into lane 2
        drive(1'b1, 15'h4, LN_WORD, 32'h11223344);
        drive(1'b1, 15'h4, LN_B2, 32'h000000AB);
        chk("b2_busy", 32'(bus_if.dmem_busy), 32'd1);
        idle(1);
        chk("b2_busy_done", 32'(bus_if.dmem_busy), 32'd0);
        load(15'h4, LN_WORD, 32'h11AB3344, 1'b0);
        idle(1);

        // half RMWs, high then low
        drive(1'b1, 15'h8, LN_WORD, 32'hFFFFFFFF);
        drive(1'b1, 15'h8, LN_HHI, 32'h00001234);
        chk("hhi_busy", 32'(bus_if.dmem_busy), 32'd1);
        idle(1);
        load(15'h8, LN_WORD, 32'h1234FFFF, 1'b0);
        drive(1'b1, 15'h8, LN_HLO, 32'h00005678);
        chk("hlo_busy", 32'(bus_if.dmem_busy), 32'd1);
        idle(1);
        load(15'h8, LN_WORD, 32'h12345678, 1'b0);
        idle(1);

        // load held across the busy cycle is accepted once and sees merged data
        drive(1'b1, 15'h20, LN_WORD, 32'hA5A5A5A5);
        drive(1'b1, 15'h20, LN_B0, 32'h0000003C);
        chk("hold_busy", 32'(bus_if.dmem_busy), 32'd1);
        drive(1'b0, 15'h20, LN_WORD, 32'h0);
        chk("hold_busy_done", 32'(bus_if.dmem_busy), 32'd0);
        load(15'h20, LN_WORD, 32'hA5A5A53C, 1'b0);
        idle(2);

        // reset during RMW_WR aborts the write-back
        drive(1'b1, 15'h2, LN_WORD, 32'h0);
        drive(1'b1, 15'h2, LN_B0, 32'h00000077);
        chk("rmw_rst_busy_pre", 32'(bus_if.dmem_busy), 32'd1);
        rst = 1'b1;
        bus_if.req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rmw_rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("rmw_rst_rsp_rdata", bus_if.rsp_rdata, 32'd0);
        chk("rmw_rst_rsp_err", 32'(bus_if.rsp_err), 32'd0);
        chk("rmw_rst_busy", 32'(bus_if.dmem_busy), 32'd0);
        rst = 1'b0;
        load(15'h2, LN_WORD, 32'h0, 1'b0);
        idle(1);

        // illegal lane code: zero data on load, no write on store
        load(15'h10, LN_ILL, 32'h0, ErrEn);
        drive(1'b1, 15'h10, LN_ILL, 32'h0);
        chk("ill_st_busy", 32'(bus_if.dmem_busy), 32'd0);
        chk("ill_st_err", 32'(bus_if.rsp_err), 32'(ErrEn));
        load(15'h10, LN_WORD, 32'hDEADBEEF, 1'b0);
        idle(1);

        // back-to-back loads
        load(15'h4, LN_WORD, 32'h11AB3344, 1'b0);
        load(15'h8, LN_B1, 32'h12345678, 1'b0);
        load(15'h20, LN_HHI, 32'hA5A5A53C, 1'b0);
        idle(2);

        // high-half store at the top address flags an error but still lands
        drive(1'b1, 15'h7FFF, LN_WORD, 32'h0);
        drive(1'b1, 15'h7FFF, LN_HHI, 32'h0000BEEF);
        chk("top_busy", 32'(bus_if.dmem_busy), 32'd1);
        chk("top_err", 32'(bus_if.rsp_err), 32'(ErrEn));
        idle(1);
        load(15'h7FFF, LN_WORD, 32'hBEEF0000, 1'b0);
        idle(1);

        // req_valid low with store-like data leaves memory alone
        bus_if.req_we      = 1'b1;
        bus_if.req_addr    = 15'h10;
        bus_if.req_byte_en = LN_WORD;
        bus_if.req_wdata   = 32'h0BADF00D;
        idle(3);
        chk("novalid_busy", 32'(bus_if.dmem_busy), 32'd0);
        load(15'h10, LN_WORD, 32'hDEADBEEF, 1'b0);
        idle(3);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
